// File: rtl/entry_pkg.sv
// entry_pkg: shared types and constants for the operand entry front end.
//   state_e        : capture/handshake FSM states
//   MODE_*         : unit-select encodings carried on the mode output
//   DATA_W_DEFAULT : default operand width
package entry_pkg;

  localparam int unsigned DATA_W_DEFAULT = 4;

  localparam logic [1:0] MODE_ARITH0 = 2'd0;
  localparam logic [1:0] MODE_ARITH1 = 2'd1;
  localparam logic [1:0] MODE_LOGIC  = 2'd2;
  localparam logic [1:0] MODE_COMP   = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes one raw active-low push-button, filters bounce
// and emits a registered one-cycle pulse when the accepted level falls.
// Build option: OPERAND_ENTRY_DEBOUNCE_EN enables the counter filter; when
// undefined the synchronizer output is taken as the accepted level.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   key   : raw button level (0 = pressed), asynchronous to clk
//   press : one-cycle pulse on an accepted 1->0 transition
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_prev_q;

  // Two-flop synchronizer, idles at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             acc_q;

  // Any sample matching the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b1;
      cnt_q <= '0;
    end else if (sync2_q == acc_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      acc_q <= ~acc_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = acc_q;
`else
  assign level = sync2_q;

  // Filter depth has no meaning without the counter; the parameter stays
  // in the interface so both builds instantiate identically.
  if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
  end
`endif

  // Registered falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b1;
      press        <= 1'b0;
    end else begin
      level_prev_q <= level;
      press        <= level_prev_q & ~level;
    end
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: push-button/switch front end for the mini-CPU datapath.
// KEY[0] press latches operands and function from SW, KEY[1] press steps the
// unit-select mode; the captured operation is offered via valid/ready.
// Build option: OPERAND_ENTRY_DEBOUNCE_EN (passed to key_debounce) enables
// the debounce counters; undefined, keys are only synchronized.
// Ports:
//   CLOCK_50 : clock
//   RESET_N  : asynchronous active-low reset
//   KEY[1:0] : raw active-low buttons (0: capture, 1: mode step)
//   SW[9:0]  : SW[9:8] func, SW[7:4] operand A, SW[3:0] operand B
//   ready    : downstream accepts the pending operation
//   op_a/op_b: captured operands
//   func     : captured function select
//   mode     : unit select captured with the operands
//   valid    : operation pending
//   overrun  : sticky, a capture press arrived while busy
module operand_entry_ctrl
  import entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DATA_W          = DATA_W_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [1:0]        KEY,
  input  logic [9:0]        SW,
  input  logic              ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        func,
  output logic [1:0]        mode,
  output logic              valid,
  output logic              overrun
);

  state_e     state_q;
  state_e     state_d;
  logic       press0;
  logic       press1;
  logic       capture_c;
  logic       drop_c;
  logic [1:0] mode_live_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key   (KEY[0]),
    .press (press0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key   (KEY[1]),
    .press (press1)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and capture/drop decisions.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    drop_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press0) begin
          capture_c = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        drop_c = press0;
        if (ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture registers, live mode counter and status flags. The capture
  // reads mode_live_q before any same-cycle increment lands.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      op_a        <= '0;
      op_b        <= '0;
      func        <= 2'd0;
      mode        <= MODE_ARITH0;
      mode_live_q <= MODE_ARITH0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (capture_c) begin
        op_a <= DATA_W'(SW[7:4]);
        op_b <= DATA_W'(SW[3:0]);
        func <= SW[9:8];
        mode <= mode_live_q;
      end
      if (press1 && (state_q == IDLE)) begin
        mode_live_q <= mode_live_q + 2'd1;
      end
      valid <= (state_d == SEND);
      if (capture_c) begin
        overrun <= 1'b0;
      end else if (drop_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl: scoreboard bench for operand_entry_ctrl. Each
// capture press pushes the expected operation; it is popped and compared
// when valid rises. Works with and without OPERAND_ENTRY_DEBOUNCE_EN.
module tb_operand_entry_ctrl;
  import entry_pkg::*;

  localparam int unsigned DEB = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int unsigned LAT = DEB + 3;
`else
  localparam int unsigned LAT = 3;
`endif
  localparam int unsigned SETTLE = 2 * DEB + 8;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] f;
    logic [1:0] m;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] key   = 2'b11;
  logic [9:0] sw    = '0;
  logic       ready = 1'b0;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [1:0] func;
  logic [1:0] mode;
  logic       valid;
  logic       overrun;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] live_mode = 2'd0;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .DATA_W(4)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY      (key),
    .SW       (sw),
    .ready    (ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .func     (func),
    .mode     (mode),
    .valid    (valid),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press of the given keys, held long enough to be accepted, then
  // released and allowed to settle so a later press is recognized.
  task automatic press_hold(input logic [1:0] mask);
    key = mask;
    tick(LAT + 2);
    key = 2'b11;
    tick(SETTLE);
  endtask

  // Drive a capture press, check latency to valid and the captured fields.
  task automatic start_op(input string tag, input logic [9:0] swv, input logic [1:0] mask);
    exp_t e;
    int   n;
    sw = swv;
    sb.push_back({swv[7:4], swv[3:0], swv[9:8], live_mode});
    if (mask[1] == 1'b0) live_mode = live_mode + 2'd1;
    key = mask;
    n = 0;
    while (!valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(LAT + 1));
    key = 2'b11;
    check_eq({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, "_op_a"}, 32'(op_a), 32'(e.a));
      check_eq({tag, "_op_b"}, 32'(op_b), 32'(e.b));
      check_eq({tag, "_func"}, 32'(func), 32'(e.f));
      check_eq({tag, "_mode"}, 32'(mode), 32'(e.m));
      check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    end
    tick(SETTLE);
    check_eq({tag, "_held"}, 32'(valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(valid), 32'd0);
  endtask

  initial begin
    logic seen;

    // Reset state.
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_op_a", 32'(op_a), 32'd0);
    check_eq("rst_op_b", 32'(op_b), 32'd0);
    check_eq("rst_func", 32'(func), 32'd0);
    check_eq("rst_mode", 32'(mode), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    check_eq("idle_valid", 32'(valid), 32'd0);

    // Basic capture; SW changes in SEND must not disturb the outputs.
    start_op("cap", 10'b10_0110_0011, 2'b10);
    sw = 10'b01_1001_1100;
    tick(3);
    check_eq("cap_sw_op_a", 32'(op_a), 32'd6);
    check_eq("cap_sw_op_b", 32'(op_b), 32'd3);
    check_eq("cap_sw_func", 32'(func), 32'd2);
    handshake("cap");

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    // Bounce shorter than the filter depth never produces a capture.
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      key[0] = ~key[0];
      repeat (2) begin
        tick(1);
        seen = seen | valid;
      end
    end
    key = 2'b11;
    tick(SETTLE);
    seen = seen | valid;
    check_eq("bounce_no_capture", 32'(seen), 32'd0);
`endif

    // Five mode steps wrap 0->1->2->3->0->1.
    for (int i = 0; i < 5; i++) begin
      press_hold(2'b01);
      live_mode = live_mode + 2'd1;
    end
    start_op("wrap", 10'b00_1111_0001, 2'b10);
    handshake("wrap");

    // Capture press while busy is dropped and flags overrun.
    start_op("ovr", 10'b11_0101_1010, 2'b10);
    sw = 10'b00_0001_0010;
    press_hold(2'b10);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_op_a", 32'(op_a), 32'd5);
    check_eq("ovr_op_b", 32'(op_b), 32'd10);
    check_eq("ovr_valid", 32'(valid), 32'd1);
    handshake("ovr");
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    start_op("ovr_clear", 10'b01_0011_0100, 2'b10);
    handshake("ovr_clear");

    // Both keys together: capture uses the pre-increment mode.
    start_op("both", 10'b10_1000_0111, 2'b00);
    // Mode step while busy is ignored.
    press_hold(2'b01);
    handshake("both");
    start_op("after_both", 10'b11_1100_0011, 2'b10);
    check_eq("after_both_mode2", 32'(mode), 32'd2);
    press_hold(2'b10);
    check_eq("pre_rst_overrun", 32'(overrun), 32'd1);

    // Asynchronous reset between edges while busy.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_overrun", 32'(overrun), 32'd0);
    check_eq("arst_op_a", 32'(op_a), 32'd0);
    check_eq("arst_mode", 32'(mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    check_eq("post_arst_valid", 32'(valid), 32'd0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
